xpb_accum_seq: RTL and testbench



---
 rtl/xpb_accum_seq.sv | 170 +++++++++++++++++
 tb/tb_xpb_accum_seq.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/xpb_accum_seq.sv
// xpb_accum_seq: walks NUM_SEG packed digits through the shared xpb LUT bank,
// one segment per cycle. It registers each LUT word and sums the words into a
// wide accumulator that feeds the final reduction adder.
// Build option: define XPB_ZERO_SKIP_EN to issue only the segments with nonzero
// digits. This does not change the sum, because the LUT maps digit 0 to value 0.
//
// state   | meaning
// S_IDLE  | ready for start, sum_out holds the last result
// S_RUN   | one LUT request per cycle, previous stage word accumulated
// S_FLUSH | no request, last stage word accumulated
// S_DONE  | done pulse, sum_out final
module xpb_accum_seq #(
  parameter  int NUM_SEG = 8,
  parameter  int SEG_W   = 5,
  parameter  int WORD_W  = 1024,
  localparam int IDX_W   = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1,
  localparam int ACC_W   = WORD_W + $clog2(NUM_SEG)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     ready,
  input  logic [NUM_SEG*SEG_W-1:0] digits_in,
  output logic                     lut_en,
  output logic [IDX_W-1:0]         lut_seg_idx,
  output logic [SEG_W-1:0]         lut_data,
  input  logic [WORD_W-1:0]        lut_value,
  output logic [ACC_W-1:0]         sum_out,
  output logic                     done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_SEG = IDX_W'(NUM_SEG - 1);

  state_t                     state_q;
  logic [NUM_SEG*SEG_W-1:0]   digits_q;
  logic [IDX_W-1:0]           cnt_q;
  logic [WORD_W-1:0]          stage_q;
  logic                       stage_vld_q;

  function automatic logic [SEG_W-1:0] seg_digit(input logic [NUM_SEG*SEG_W-1:0] d,
                                                 input logic [IDX_W-1:0]         idx);
    return d[int'(idx)*SEG_W +: SEG_W];
  endfunction

`ifdef XPB_ZERO_SKIP_EN
  logic             first_hit;
  logic [IDX_W-1:0] first_idx;
  logic             nxt_hit;
  logic [IDX_W-1:0] nxt_idx;

  // Priority search for the lowest nonzero segment, both in the incoming vector
  // and above the current counter in the latched vector. Because the loop runs
  // downward, the last match it records is the lowest index.
  always_comb begin
    first_hit = 1'b0;
    first_idx = '0;
    nxt_hit   = 1'b0;
    nxt_idx   = '0;
    for (int i = NUM_SEG - 1; i >= 0; i--) begin
      if (digits_in[i*SEG_W +: SEG_W] != '0) begin
        first_hit = 1'b1;
        first_idx = IDX_W'(i);
      end
      if ((i > int'(cnt_q)) && (digits_q[i*SEG_W +: SEG_W] != '0)) begin
        nxt_hit = 1'b1;
        nxt_idx = IDX_W'(i);
      end
    end
  end
`endif

  // Sequencer FSM with registered LUT request, stage register and accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ready       <= 1'b1;
      digits_q    <= '0;
      cnt_q       <= '0;
      stage_q     <= '0;
      stage_vld_q <= 1'b0;
      lut_en      <= 1'b0;
      lut_seg_idx <= '0;
      lut_data    <= '0;
      sum_out     <= '0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            digits_q    <= digits_in;
            sum_out     <= '0;
            stage_vld_q <= 1'b0;
            ready       <= 1'b0;
`ifdef XPB_ZERO_SKIP_EN
            if (first_hit) begin
              cnt_q       <= first_idx;
              lut_en      <= 1'b1;
              lut_seg_idx <= first_idx;
              lut_data    <= seg_digit(digits_in, first_idx);
              state_q     <= S_RUN;
            end else begin
              // Nothing to issue: the flush cycle still runs, so that done lands
              // in the cycle after edge 1.
              cnt_q    <= '0;
              lut_en   <= 1'b0;
              lut_data <= '0;
              state_q  <= S_FLUSH;
            end
`else
            cnt_q       <= '0;
            lut_en      <= 1'b1;
            lut_seg_idx <= '0;
            lut_data    <= seg_digit(digits_in, '0);
            state_q     <= S_RUN;
`endif
          end
        end
        S_RUN: begin
          stage_q     <= lut_value;
          stage_vld_q <= 1'b1;
          if (stage_vld_q) begin
            sum_out <= sum_out + ACC_W'(stage_q);
          end
`ifdef XPB_ZERO_SKIP_EN
          if (nxt_hit) begin
            cnt_q       <= nxt_idx;
            lut_seg_idx <= nxt_idx;
            lut_data    <= seg_digit(digits_q, nxt_idx);
          end else begin
            lut_en   <= 1'b0;
            lut_data <= '0;
            state_q  <= S_FLUSH;
          end
`else
          if (cnt_q == LAST_SEG) begin
            lut_en   <= 1'b0;
            lut_data <= '0;
            state_q  <= S_FLUSH;
          end else begin
            cnt_q       <= cnt_q + IDX_W'(1);
            lut_seg_idx <= cnt_q + IDX_W'(1);
            lut_data    <= seg_digit(digits_q, cnt_q + IDX_W'(1));
          end
`endif
        end
        S_FLUSH: begin
          if (stage_vld_q) begin
            sum_out <= sum_out + ACC_W'(stage_q);
          end
          stage_vld_q <= 1'b0;
          done        <= 1'b1;
          state_q     <= S_DONE;
        end
        S_DONE: begin
          ready   <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          ready   <= 1'b1;
          lut_en  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xpb_accum_seq.sv
// Directed testbench for xpb_accum_seq with default parameters.
// LUT model: digit 0 -> 0, otherwise ((idx+1) << 1000) | digit, or all ones.
module tb_xpb_accum_seq;

  localparam int ACC_W = 1027;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              start = 1'b0;
  logic              ready;
  logic [39:0]       digits_in = '0;
  logic              lut_en;
  logic [2:0]        lut_seg_idx;
  logic [4:0]        lut_data;
  logic [1023:0]     lut_value;
  logic [ACC_W-1:0]  sum_out;
  logic              done;

  int checks = 0;
  int errors = 0;
  bit all_ones = 1'b0;

  xpb_accum_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .ready       (ready),
    .digits_in   (digits_in),
    .lut_en      (lut_en),
    .lut_seg_idx (lut_seg_idx),
    .lut_data    (lut_data),
    .lut_value   (lut_value),
    .sum_out     (sum_out),
    .done        (done)
  );

  always #5 clk = ~clk;

  always_comb begin
    if (all_ones) lut_value = '1;
    else if (lut_data == 5'd0) lut_value = '0;
    else lut_value = ((1024'(lut_seg_idx) + 1024'd1) << 1000) | 1024'(lut_data);
  end

  task automatic chk(input string tag, input logic [ACC_W-1:0] obs, input logic [ACC_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed hi=%h lo=%h expected hi=%h lo=%h", tag,
             obs[ACC_W-1:1000], obs[63:0], exp[ACC_W-1:1000], exp[63:0]);
    end
  endtask

  // One full operation: checks request sequence, done timing, sum and hold.
  task automatic run_op(input logic [39:0] d, input logic [ACC_W-1:0] exp_sum,
                        input int exp_edge, input int exp_cnt);
    int e;
    int n;
    int guard;
    int exp_idx[$];
    for (int i = 0; i < 8; i++) begin
`ifdef XPB_ZERO_SKIP_EN
      if (d[i*5 +: 5] != 5'd0) exp_idx.push_back(i);
`else
      exp_idx.push_back(i);
`endif
    end
    guard = 0;
    while (!ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("ready_before_start", ACC_W'(ready), 1);
    digits_in = d;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    digits_in = ~d;
    chk("ready_low_after_accept", ACC_W'(ready), 0);
    e = 0;
    n = 0;
    while (!done && e < 40) begin
      if (lut_en) begin
        if (n < exp_idx.size()) begin
          chk("lut_seg_idx", ACC_W'(lut_seg_idx), ACC_W'(exp_idx[n]));
          chk("lut_data", ACC_W'(lut_data), ACC_W'(d[exp_idx[n]*5 +: 5]));
        end
        n++;
      end else begin
        chk("lut_data_when_idle", ACC_W'(lut_data), 0);
      end
      @(posedge clk); #1;
      e++;
    end
    chk("done_seen", ACC_W'(done), 1);
    chk("done_edge", ACC_W'(e), ACC_W'(exp_edge));
    chk("sum_out", sum_out, exp_sum);
    chk("lut_en_count", ACC_W'(n), ACC_W'(exp_cnt));
    chk("ready_in_done", ACC_W'(ready), 0);
    @(posedge clk); #1;
    chk("done_one_cycle", ACC_W'(done), 0);
    chk("ready_back", ACC_W'(ready), 1);
    chk("sum_hold", sum_out, exp_sum);
    digits_in = '0;
  endtask

  initial begin
    logic [39:0]      d_ones;
    logic [39:0]      d_ramp;
    logic [39:0]      d_sparse;
    logic [ACC_W-1:0] sum_ones;
    logic [ACC_W-1:0] sum_ramp;
    int e;
    int d1;
    int d2;
    int guard;
    int done_hits;

    d_ones   = {8{5'd1}};
    d_ramp   = {5'd9, 5'd8, 5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2};
    d_sparse = '0;
    d_sparse[2*5 +: 5] = 5'd3;
    d_sparse[6*5 +: 5] = 5'd7;
    sum_ones = (1027'd36 << 1000) + 1027'd8;
    sum_ramp = (1027'd36 << 1000) + 1027'd44;

    // reset values
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ready", ACC_W'(ready), 1);
    chk("rst_lut_en", ACC_W'(lut_en), 0);
    chk("rst_lut_seg_idx", ACC_W'(lut_seg_idx), 0);
    chk("rst_lut_data", ACC_W'(lut_data), 0);
    chk("rst_sum_out", sum_out, 0);
    chk("rst_done", ACC_W'(done), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // all digits 1
    run_op(d_ones, sum_ones, 9, 8);

    // carry chain: LUT all ones, digits all 1F
    all_ones = 1'b1;
    run_op({8{5'h1F}}, {ACC_W{1'b1}} - 1027'd7, 9, 8);
    all_ones = 1'b0;

    // start held high: two back-to-back operations
    digits_in = d_ones;
    start = 1'b1;
    @(posedge clk); #1;
    digits_in = d_ramp;
    e = 0;
    d1 = -1;
    d2 = -1;
    while (d2 < 0 && e < 40) begin
      if (e == 5) chk("b2b_ready_low", ACC_W'(ready), 0);
      if (done) begin
        if (d1 < 0) begin
          d1 = e;
          chk("b2b_sum_first", sum_out, sum_ones);
        end else begin
          d2 = e;
          chk("b2b_sum_second", sum_out, sum_ramp);
          start = 1'b0;
        end
      end
      if (d2 < 0) begin
        @(posedge clk); #1;
        e++;
      end
    end
    start = 1'b0;
    chk("b2b_first_done_edge", ACC_W'(d1), 9);
    chk("b2b_done_spacing", ACC_W'(d2 - d1), 11);
    @(posedge clk); #1;
    chk("b2b_ready_after", ACC_W'(ready), 1);

    // async reset during RUN at segment 4
    digits_in = d_ones;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    guard = 0;
    while (!(lut_en && lut_seg_idx == 3'd4) && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("abort_reached_seg4", ACC_W'(lut_seg_idx), 4);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_ready", ACC_W'(ready), 1);
    chk("abort_lut_en", ACC_W'(lut_en), 0);
    chk("abort_lut_seg_idx", ACC_W'(lut_seg_idx), 0);
    chk("abort_lut_data", ACC_W'(lut_data), 0);
    chk("abort_sum_out", sum_out, 0);
    chk("abort_done", ACC_W'(done), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    done_hits = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) done_hits++;
    end
    chk("abort_no_done", ACC_W'(done_hits), 0);
    run_op(d_ones, sum_ones, 9, 8);

    // sparse and all-zero digit vectors
`ifdef XPB_ZERO_SKIP_EN
    run_op(d_sparse, (1027'd10 << 1000) + 1027'd10, 3, 2);
    run_op('0, '0, 1, 0);
`else
    run_op(d_sparse, (1027'd10 << 1000) + 1027'd10, 9, 8);
    run_op('0, '0, 9, 8);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
